// File: rtl/enc_stream_seq_pkg.sv
// Shared types and constants for the encrypt-stage stream sequencer.
package enc_stream_seq_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [BYTE_W-1:0] ZERO_SEED_SUB = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // An all-zero LFSR never leaves zero, so substitute a live seed.
    function automatic logic [BYTE_W-1:0] seed_fix(
        input logic [BYTE_W-1:0] s
    );
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

    function automatic logic [BYTE_W-1:0] lfsr_next(
        input logic [BYTE_W-1:0] k
    );
        return {k[BYTE_W-2:0], ^(k & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/enc_stream_seq_if.sv
// Byte stream in/out and ENCRYPT-side bus of the stream sequencer.
interface enc_stream_seq_if;
    import enc_stream_seq_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic [BYTE_W-1:0] enc_num;
    logic [BYTE_W-1:0] enc_key;
    logic [BYTE_W-1:0] enc_result;
    logic              out_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_ready;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output enc_num, enc_key,
        input  enc_result,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  enc_num, enc_key,
        output enc_result,
        input  out_valid, out_data,
        output out_ready
    );

endinterface

// File: rtl/enc_stream_seq_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module enc_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/enc_stream_seq.sv
// Feeds ENCRYPT with LFSR-keyed bytes and collects results in a FIFO.
// Optional ENC_STREAM_BYTE_CNT_EN adds a 16-bit popped-byte counter.
module enc_stream_seq
    import enc_stream_seq_pkg::*;
#(
    parameter int ENC_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [BYTE_W-1:0] key_seed,
    enc_stream_seq_if.master  bus,
`ifdef ENC_STREAM_BYTE_CNT_EN
    output logic [15:0]       byte_cnt,
`endif
    output logic              busy
);

    localparam int PW  = ENC_LATENCY + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + PW + 1) + 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] key_q, key_d;
    logic [BYTE_W-1:0] pend_q, pend_d;
    logic [BYTE_W-1:0] num_q, num_d;
    logic [BYTE_W-1:0] ekey_q, ekey_d;
    logic [PW-1:0]     pipe_q, pipe_d;
    logic [CW-1:0]     inflight;
    logic [FCW-1:0]    fifo_cnt;
    logic              pipe_empty;
    logic              accept;
    logic              push;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PW; i++) inflight = inflight + CW'(pipe_q[i]);
    end

    // Counting in-flight tokens keeps the FIFO from ever overflowing.
    assign bus.in_ready = (state_q == ST_RUN) && !key_load &&
                          ((CW'(fifo_cnt) + inflight) < CW'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign pipe_empty   = (pipe_q == '0);
    assign push         = pipe_q[PW-1];

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pend_d  = pend_q;
        num_d   = num_q;
        ekey_d  = ekey_q;
        pipe_d  = {pipe_q[PW-2:0], accept};
        unique case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    key_d   = seed_fix(key_seed);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (key_load) begin
                    if (pipe_empty) begin
                        key_d = seed_fix(key_seed);
                    end else begin
                        pend_d  = key_seed;
                        state_d = ST_DRAIN;
                    end
                end else if (accept) begin
                    num_d  = bus.in_data;
                    ekey_d = key_q;
                    key_d  = lfsr_next(key_q);
                end
            end
            ST_DRAIN: begin
                if (key_load) pend_d = key_seed;
                if (pipe_empty) begin
                    key_d   = seed_fix(key_load ? key_seed : pend_q);
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            pend_q  <= '0;
            num_q   <= '0;
            ekey_q  <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pend_q  <= pend_d;
            num_q   <= num_d;
            ekey_q  <= ekey_d;
            pipe_q  <= pipe_d;
        end
    end

    assign bus.enc_num = num_q;
    assign bus.enc_key = ekey_q;

    enc_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (bus.enc_result),
        .pop_i   (bus.out_ready),
        .data_o  (bus.out_data),
        .valid_o (bus.out_valid),
        .count_o (fifo_cnt)
    );

    assign busy = !pipe_empty || bus.out_valid;

`ifdef ENC_STREAM_BYTE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.out_valid && bus.out_ready) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign byte_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_enc_stream_seq.sv
// Self-checking bench for enc_stream_seq with a behavioural ENCRYPT model.
module tb_enc_stream_seq;
    import enc_stream_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_load = 1'b0;
    logic [7:0] key_seed = 8'h00;
    logic       busy;
`ifdef ENC_STREAM_BYTE_CNT_EN
    logic [15:0] byte_cnt;
`endif

    enc_stream_seq_if bus();

    enc_stream_seq #(.ENC_LATENCY(1), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_load (key_load),
        .key_seed (key_seed),
        .bus      (bus),
`ifdef ENC_STREAM_BYTE_CNT_EN
        .byte_cnt (byte_cnt),
`endif
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    // ENCRYPT stand-in: registered inputs, result = number XOR key
    logic [7:0] er_num = 8'h00;
    logic [7:0] er_key = 8'h00;
    always @(posedge clk) begin
        er_num <= bus.enc_num;
        er_key <= bus.enc_key;
    end
    assign bus.enc_result = er_num ^ er_key;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] k);
        return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
    endfunction

    typedef struct {
        logic [7:0] v;
        int         rdy;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  key_m = 8'h00;
    bit          loaded = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    logic [15:0] pops = 0;
    bit          chk_drv;
    logic [7:0]  drv_num, drv_key;

    // One clock: model/scoreboard at negedge, drive checks 1ns after posedge
    task automatic tick();
        @(negedge clk);
        chk_drv = 0;
        if (reset) begin
            q.delete();
            loaded = 0;
            pops = 0;
        end else begin
            chk("busy", 16'(busy), 16'(q.size() != 0));
            if (!loaded || key_load || q.size() >= 4)
                chk("in_ready_off", 16'(bus.in_ready), 16'd0);
            chk("out_valid", 16'(bus.out_valid), 16'(q.size() > 0 && q[0].rdy <= cyc));
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                chk("out_data", 16'(bus.out_data), 16'(q[0].v));
                void'(q.pop_front());
                pops++;
            end
            if (key_load) begin
                key_m = (key_seed == 8'h00) ? 8'h01 : key_seed;
                loaded = 1;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{v: bus.in_data ^ key_m, rdy: cyc + 3});
                drv_num = bus.in_data;
                drv_key = key_m;
                key_m = nxt(key_m);
                chk_drv = 1;
                acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (chk_drv) begin
            chk("enc_num", 16'(bus.enc_num), 16'(drv_num));
            chk("enc_key", 16'(bus.enc_key), 16'(drv_key));
        end
`ifdef ENC_STREAM_BYTE_CNT_EN
        chk("byte_cnt", byte_cnt, pops);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_load = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] s);
        key_load = 1'b1;
        key_seed = s;
        tick();
        key_load = 1'b0;
    endtask

    typedef struct {
        logic [7:0] seed;
        logic [7:0] d0;
        logic [7:0] key0;
        logic [7:0] out0;
        logic [7:0] key1;
    } vec_t;

    vec_t tbl[4];
    int   a0;
    bit   got;

    initial begin
        tbl[0] = '{8'h93, 8'h46, 8'h93, 8'hD5, 8'h26};
        tbl[1] = '{8'h00, 8'h3C, 8'h01, 8'h3D, 8'h02};
        tbl[2] = '{8'h5A, 8'hA5, 8'h5A, 8'hFF, 8'hB4};
        tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE};

        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_out_data", 16'(bus.out_data), 16'd0);
        chk("rst_enc_num", 16'(bus.enc_num), 16'd0);
        chk("rst_enc_key", 16'(bus.enc_key), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", 16'(bus.in_ready), 16'd0);

        // key schedule and latency table
        for (int i = 0; i < 4; i++) begin
            do_reset();
            load(tbl[i].seed);
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data = tbl[i].d0;
            tick();
            chk("tbl_key0", 16'(bus.enc_key), 16'(tbl[i].key0));
            chk("tbl_num0", 16'(bus.enc_num), 16'(tbl[i].d0));
            bus.in_data = 8'h00;
            tick();
            chk("tbl_key1", 16'(bus.enc_key), 16'(tbl[i].key1));
            chk("tbl_early", 16'(bus.out_valid), 16'd0);
            bus.in_valid = 1'b0;
            tick();
            chk("tbl_valid", 16'(bus.out_valid), 16'd1);
            chk("tbl_out0", 16'(bus.out_data), 16'(tbl[i].out0));
            tick();
            chk("tbl_out1", 16'(bus.out_data), 16'(tbl[i].key1));
            tick();
            tick();
            bus.out_ready = 1'b0;
        end

        // fill to capacity under backpressure, then drain in order
        do_reset();
        load(8'h11);
        bus.in_valid = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'(8'h20 + i);
            tick();
        end
        chk("fill_accepts", 16'(acc_cnt - a0), 16'd4);
        chk("fill_in_ready", 16'(bus.in_ready), 16'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("fill_drained", 16'(busy), 16'd0);

        // key_load while a byte is in flight
        do_reset();
        load(8'h11);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        tick();
        bus.in_data = 8'h88;
        key_load = 1'b1;
        key_seed = 8'h5A;
        tick();
        key_load = 1'b0;
        got = 0;
        a0 = acc_cnt;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = (acc_cnt != a0);
        end
        chk("drain_accept", 16'(got), 16'd1);
        chk("drain_key", 16'(bus.enc_key), 16'h005A);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // push and pop together at three entries, across pointer wrap
        do_reset();
        load(8'h3C);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'(8'h50 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = 8'(8'h60 + i);
            tick();
            chk("pp_in_ready", 16'(bus.in_ready), 16'd1);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // reset with two bytes queued and one in flight
        do_reset();
        load(8'h42);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'(8'hC0 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 16'(bus.out_valid), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_ready", 16'(bus.in_ready), 16'd0);
        chk("mid_rst_data", 16'(bus.out_data), 16'd0);

        // randomized traffic against the scoreboard
        load(8'($urandom));
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom % 4) != 0;
            bus.in_data = 8'($urandom);
            bus.out_ready = ($urandom % 3) != 0;
            key_load = ($urandom % 64) == 0;
            key_seed = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end
        key_load = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && busy; i++) tick();
        chk("rand_drained", 16'(busy), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
